// File: rtl/ita_step_sequencer_if.sv
// ita_step_sequencer_if: step enum plus the sequencer's control/status bundle.
package ita_step_pkg;
  typedef enum logic [2:0] {
    STEP_Q, STEP_K, STEP_V, STEP_QK, STEP_AV, STEP_OW, STEP_F1, STEP_F2
  } step_e;
endpackage

interface ita_step_sequencer_if
  import ita_step_pkg::*;
#(
  parameter int TILE_CNT_W = 8,
  parameter int N_STEPS    = 8
);
  logic                          start_i;
  logic                          layer_ffn_i;
  logic [N_STEPS*TILE_CNT_W-1:0] n_tiles_i;
  logic                          tile_done_i;
  logic                          drain_done_i;
  step_e                         step_o;
  logic                          step_valid_o;
  logic                          step_change_o;
  logic [TILE_CNT_W-1:0]         tile_idx_o;
  logic                          busy_o;
  logic                          done_o;
  modport master (
    output start_i, layer_ffn_i, n_tiles_i, tile_done_i, drain_done_i,
    input  step_o, step_valid_o, step_change_o, tile_idx_o, busy_o, done_o
  );
  modport slave (
    input  start_i, layer_ffn_i, n_tiles_i, tile_done_i, drain_done_i,
    output step_o, step_valid_o, step_change_o, tile_idx_o, busy_o, done_o
  );
endinterface

// File: rtl/ita_step_sequencer.sv
// ita_step_sequencer: walks attention/FFN steps tile by tile, then waits for drain.
module ita_step_sequencer
  import ita_step_pkg::*;
#(
  parameter int TILE_CNT_W = 8,
  parameter int N_STEPS    = 8
) (
  input logic                 clk_i,
  input logic                 rst_i,
  ita_step_sequencer_if.slave bus
);
  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_e;
  state_e                        state, state_n;
  step_e                         step, step_n;
  logic [TILE_CNT_W-1:0]         idx, idx_n, cur_n;
  logic                          cfg_ffn, cfg_ffn_n, change, change_n;
  logic [N_STEPS*TILE_CNT_W-1:0] cfg_tiles, cfg_tiles_n;
  logic [3:0]                    hit;
  // Lowest nonzero-count step at or above lo within the chosen sequence: {found, step}.
  function automatic logic [3:0] seek(input int lo, input logic ffn,
                                      input logic [N_STEPS*TILE_CNT_W-1:0] t);
    seek = '0;
    for (int k = N_STEPS - 1; k >= 0; k--)
      if (k >= lo && k <= (ffn ? N_STEPS - 1 : N_STEPS - 3) && t[k*TILE_CNT_W +: TILE_CNT_W] != '0)
        seek = {1'b1, 3'(k)};
  endfunction
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state     <= IDLE;
      step      <= STEP_Q;
      idx       <= '0;
      cfg_ffn   <= 1'b0;
      cfg_tiles <= '0;
      change    <= 1'b0;
    end else begin
      state     <= state_n;
      step      <= step_n;
      idx       <= idx_n;
      cfg_ffn   <= cfg_ffn_n;
      cfg_tiles <= cfg_tiles_n;
      change    <= change_n;
    end
  end
  always_comb begin
    hit = seek(state == IDLE ? (bus.layer_ffn_i ? N_STEPS - 2 : 0) : int'(step) + 1,
               state == IDLE ? bus.layer_ffn_i : cfg_ffn,
               state == IDLE ? bus.n_tiles_i : cfg_tiles);
    cur_n       = cfg_tiles[int'(step)*TILE_CNT_W +: TILE_CNT_W];
    state_n     = state;
    step_n      = step;
    idx_n       = idx;
    cfg_ffn_n   = cfg_ffn;
    cfg_tiles_n = cfg_tiles;
    change_n    = 1'b0;
    case (state)
      IDLE: if (bus.start_i) begin
        cfg_ffn_n   = bus.layer_ffn_i;
        cfg_tiles_n = bus.n_tiles_i;
        state_n     = hit[3] ? RUN : DRAIN;
        step_n      = hit[3] ? step_e'(hit[2:0]) : step;
        change_n    = hit[3];
      end
      RUN: if (bus.tile_done_i) begin
        if (idx != cur_n - 1'b1) idx_n = idx + 1'b1;
        else begin
          idx_n    = '0;
          state_n  = hit[3] ? RUN : DRAIN;
          step_n   = hit[3] ? step_e'(hit[2:0]) : step;
          change_n = hit[3];
        end
      end
      DRAIN: state_n = bus.drain_done_i ? DONE : DRAIN;
      default: begin
        state_n = IDLE;
        step_n  = STEP_Q;
        idx_n   = '0;
      end
    endcase
  end
  always_comb begin
    bus.step_o        = step;
    bus.step_valid_o  = state == RUN;
    bus.step_change_o = change;
    bus.tile_idx_o    = idx;
    bus.busy_o        = state != IDLE;
    bus.done_o        = state == DONE;
  end
endmodule

// File: tb/tb_ita_step_sequencer.sv
// tb_ita_step_sequencer: random-stimulus bench checked against a tile-queue model.
module tb_ita_step_sequencer;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  ita_step_sequencer_if bus ();
  ita_step_sequencer dut (.clk_i(clk), .rst_i(rst), .bus(bus));
  int checks = 0;
  int fails = 0;
  typedef struct {logic [2:0] s; logic [7:0] i;} tile_t;
  logic [14:0] got;
  always_comb got = {bus.step_valid_o, bus.busy_o, bus.done_o, bus.step_change_o,
                     3'(bus.step_o), bus.tile_idx_o};

  task automatic idle_inputs();
    bus.start_i = 0; bus.layer_ffn_i = 0; bus.n_tiles_i = '0;
    bus.tile_done_i = 0; bus.drain_done_i = 0;
  endtask

  // Expected behaviour: the layer is the ordered list of (step, tile) pairs; each tile_done
  // in RUN consumes one, then drain wait, one DONE cycle, back to IDLE.
  task automatic run_layer(input logic ffn, input logic [63:0] tiles, input int pct,
                           input int period, input int drain_wait, input string name);
    tile_t q[$];
    logic [2:0] last = 0;
    logic [14:0] exp;
    logic fresh = 1, td, dd;
    int ph, dcnt = 0, cyc = 0;
    for (int k = (ffn ? 6 : 0); k <= (ffn ? 7 : 5); k++)
      for (int i = 0; i < int'(tiles[k*8 +: 8]); i++) q.push_back('{3'(k), 8'(i)});
    bus.start_i = 1; bus.layer_ffn_i = ffn; bus.n_tiles_i = tiles;
    bus.tile_done_i = 0; bus.drain_done_i = 0;
    @(negedge clk);
    ph = q.size() != 0 ? 1 : 2;
    while (ph != 0 && cyc < 4000) begin
      exp = {ph == 1, 1'b1, ph == 3, ph == 1 && fresh,
             ph == 1 ? q[0].s : last, ph == 1 ? q[0].i : 8'd0};
      checks++;
      if (got !== exp) begin
        fails++;
        $display("FAIL %s cyc %0d: got %h required %h", name, cyc, got, exp);
      end
      td = period > 0 ? (cyc % period == period - 1) : ($urandom_range(99) < pct);
      dd = ph == 2 ? dcnt >= drain_wait : 1'($urandom);
      bus.tile_done_i = td; bus.drain_done_i = dd;
      bus.start_i = 1'($urandom); bus.layer_ffn_i = 1'($urandom);
      bus.n_tiles_i = {$urandom, $urandom};
      fresh = 0;
      case (ph)
        1: if (td) begin
          last = q[0].s;
          void'(q.pop_front());
          if (q.size() == 0) ph = 2; else fresh = q[0].i == 0;
        end
        2: if (dd) ph = 3; else dcnt++;
        default: ph = 0;
      endcase
      @(negedge clk);
      cyc++;
    end
    checks++;
    if (ph != 0 || got !== 15'd0) begin
      fails++;
      $display("FAIL %s end idle: got %h required 0000 (timeout %0d)", name, got, ph != 0);
    end
    idle_inputs();
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1;
    repeat (3) @(negedge clk);
    checks++;
    if (got !== 15'd0) begin fails++; $display("FAIL reset: got %h required 0000", got); end
    rst = 0;
    @(negedge clk);
  endtask

  task automatic test_attention();
    run_layer(0, {8'd9, 8'd9, 8'd3, 8'd1, 8'd1, 8'd2, 8'd2, 8'd2}, 100, 0, 0, "attention");
  endtask

  task automatic test_ffn();
    run_layer(1, {8'd1, 8'd4, 8'd5, 8'd5, 8'd5, 8'd5, 8'd5, 8'd5}, 0, 3, 0, "ffn");
  endtask

  task automatic test_zero_skip();
    run_layer(0, {8'd0, 8'd0, 8'd1, 8'd1, 8'd1, 8'd0, 8'd0, 8'd1}, 100, 0, 0, "zero_skip");
    run_layer(0, {8'd7, 8'd7, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0}, 100, 0, 0, "all_zero_att");
    run_layer(1, {8'd0, 8'd0, 8'd3, 8'd3, 8'd3, 8'd3, 8'd3, 8'd3}, 100, 0, 0, "all_zero_ffn");
  endtask

  task automatic test_drain_hold();
    run_layer(0, {16'd0, 48'h010203040506}, 70, 0, 5, "drain_hold");
  endtask

  task automatic test_back_to_back();
    run_layer(1, {8'd2, 8'd2, 48'd0}, 100, 0, 0, "b2b_a");
    run_layer(0, {16'd0, 48'h000000000102}, 100, 0, 0, "b2b_b");
  endtask

  task automatic test_reset_mid();
    bus.start_i = 1; bus.layer_ffn_i = 0; bus.n_tiles_i = {16'd0, 48'h010101010301};
    @(negedge clk);
    bus.start_i = 0; bus.tile_done_i = 1;
    repeat (2) @(negedge clk);
    checks++;
    if (got !== {4'b1100, 3'd1, 8'd1}) begin
      fails++; $display("FAIL reset_mid pre: got %h required %h", got, {4'b1100, 3'd1, 8'd1});
    end
    rst = 1;
    @(negedge clk);
    rst = 0; bus.tile_done_i = 0;
    for (int c = 0; c < 4; c++) begin
      checks++;
      if (got !== 15'd0) begin fails++; $display("FAIL reset_mid c%0d: got %h required 0000", c, got); end
      @(negedge clk);
    end
  endtask

  task automatic test_ignored_idle();
    bus.tile_done_i = 1; bus.drain_done_i = 1;
    repeat (3) @(negedge clk);
    checks++;
    if (got !== 15'd0) begin fails++; $display("FAIL ignored_idle: got %h required 0000", got); end
    idle_inputs();
    run_layer(0, {16'd0, 48'h000000000003}, 60, 0, 2, "after_idle_tiles");
  endtask

  task automatic test_random();
    logic [63:0] t;
    for (int n = 0; n < 25; n++) begin
      for (int k = 0; k < 8; k++)
        t[k*8 +: 8] = $urandom_range(3) == 0 ? 8'd0 : 8'($urandom_range(1, 4));
      if (n == 0) t[7:0] = 8'd255;
      run_layer(1'($urandom), t, $urandom_range(30, 100), 0, $urandom_range(0, 3), "random");
    end
  endtask

  initial begin
    test_reset();
    test_attention();
    test_ffn();
    test_zero_skip();
    test_drain_hold();
    test_back_to_back();
    test_reset_mid();
    test_ignored_idle();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
